// File: rtl/psc_trigger_pkg.sv
// Shared types and default frame geometry for the PSC trigger/status transmit path.
package psc_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIG   = 2'd1,
    STATUS = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam int TRIG_LEN_DEF      = 4;
  localparam int STATUS_LEN_DEF    = 8;
  localparam int GAP_BYTES_DEF     = 2;
  localparam int STATUS_PERIOD_DEF = 100;
  localparam int ADDR_W_DEF        = 4;
  localparam int DROP_W_DEF        = 8;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psc_trigger_status_timer.sv
// Byte-tick period counter; pulses wrap on the tick that returns it to zero.
module psc_trigger_status_timer
  import psc_trigger_pkg::*;
#(
  parameter int PERIOD = STATUS_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic byte_tick,
  input  logic enable,
  output logic wrap
);

  localparam int CNT_W = cnt_width(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (byte_tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign wrap = enable && byte_tick && (cnt == LAST);

endmodule

// File: rtl/psc_trigger_tx_scheduler.sv
// Chooses trigger or status frames for the PSC link and walks the ROM address one byte per tick.
//   state  | meaning
//   IDLE   | no frame; starts a pending trigger (first) or status frame on an enabled tick
//   TRIG   | emitting trigger frame bytes, never preempted
//   STATUS | emitting status frame bytes, aborted by a pending trigger
//   GAP    | silent byte slots after a completed frame
module psc_trigger_tx_scheduler
  import psc_trigger_pkg::*;
#(
  parameter int TRIG_LEN      = TRIG_LEN_DEF,
  parameter int STATUS_LEN    = STATUS_LEN_DEF,
  parameter int GAP_BYTES     = GAP_BYTES_DEF,
  parameter int STATUS_PERIOD = STATUS_PERIOD_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DROP_W        = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_tick,
  input  logic              enable,
  input  logic              trig_req,
  input  logic              status_req,
  output logic [ADDR_W-1:0] addr,
  output logic              is_trigger,
  output logic              byte_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  localparam int GAP_W = cnt_width(GAP_BYTES);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_BYTES > 0) ? GAP_BYTES - 1 : 0);
  localparam logic [ADDR_W-1:0] TRIG_LAST = ADDR_W'(TRIG_LEN - 1);
  localparam logic [ADDR_W-1:0] STAT_LAST = ADDR_W'(STATUS_LEN - 1);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  state_e            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              is_trigger_d;
  logic              byte_valid_d;
  logic              frame_start_d;
  logic              frame_done_d;
  logic              frame_abort_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic              trig_pend, trig_pend_d;
  logic              stat_pend, stat_pend_d;
  logic              trig_clr, stat_clr, abort_set;
  logic              emit, emit_trig, emit_last;
  logic [ADDR_W-1:0] emit_addr;
  logic              timer_wrap;

  psc_trigger_status_timer #(
    .PERIOD(STATUS_PERIOD)
  ) u_status_timer (
    .clk      (clk),
    .reset    (reset),
    .byte_tick(byte_tick),
    .enable   (enable),
    .wrap     (timer_wrap)
  );

  always_comb begin
    state_d       = state;
    addr_d        = addr;
    is_trigger_d  = is_trigger;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    gap_cnt_d     = gap_cnt;
    trig_clr      = 1'b0;
    stat_clr      = 1'b0;
    abort_set     = 1'b0;
    emit          = 1'b0;
    emit_trig     = 1'b0;
    emit_addr     = '0;
    emit_last     = 1'b0;

    if (byte_tick) begin
      unique case (state)
        IDLE: begin
          addr_d = '0;
          if (enable && trig_pend) begin
            emit      = 1'b1;
            emit_trig = 1'b1;
            trig_clr  = 1'b1;
          end else if (enable && stat_pend) begin
            emit     = 1'b1;
            stat_clr = 1'b1;
          end
        end
        TRIG: begin
          emit      = 1'b1;
          emit_trig = 1'b1;
          emit_addr = addr + 1'b1;
        end
        STATUS: begin
          emit = 1'b1;
          // A pending trigger takes the next byte slot; the status frame is resent later.
          if (trig_pend) begin
            emit_trig     = 1'b1;
            trig_clr      = 1'b1;
            abort_set     = 1'b1;
            frame_abort_d = 1'b1;
          end else begin
            emit_addr = addr + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state_d = IDLE;
            addr_d  = '0;
          end else begin
            gap_cnt_d = gap_cnt - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (emit) begin
        emit_last     = (emit_addr == (emit_trig ? TRIG_LAST : STAT_LAST));
        addr_d        = emit_addr;
        is_trigger_d  = emit_trig;
        byte_valid_d  = 1'b1;
        frame_start_d = (emit_addr == '0);
        frame_done_d  = emit_last;
        if (emit_last) begin
          state_d   = (GAP_BYTES > 0) ? GAP : IDLE;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = emit_trig ? TRIG : STATUS;
        end
      end
    end

    // New requests in the same cycle as a consume keep the flag set.
    trig_pend_d = (trig_pend && !trig_clr) || trig_req;
    stat_pend_d = (stat_pend && !stat_clr) || status_req || timer_wrap || abort_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= '0;
      is_trigger  <= 1'b0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      gap_cnt     <= '0;
      trig_pend   <= 1'b0;
      stat_pend   <= 1'b0;
      drop_count  <= '0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      is_trigger  <= is_trigger_d;
      byte_valid  <= byte_valid_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
      frame_abort <= frame_abort_d;
      gap_cnt     <= gap_cnt_d;
      trig_pend   <= trig_pend_d;
      stat_pend   <= stat_pend_d;
      if (trig_req && trig_pend && (drop_count != DROP_MAX)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_psc_trigger_tx_scheduler.sv
// Directed per-tick vector table plus hand-written sequences for timer, overrun, enable and reset.
module tb_psc_trigger_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_tick = 1'b0;
  logic       enable = 1'b0;
  logic       trig_req = 1'b0;
  logic       status_req = 1'b0;
  logic [3:0] addr;
  logic       is_trigger, byte_valid, frame_start, frame_done, frame_abort, busy;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         tr;
    bit         sr;
    bit         bv;
    logic [3:0] a;
    bit         it;
    bit         fs;
    bit         fd;
    bit         fa;
    bit         bs;
  } vec_t;

  vec_t vq[$];

  psc_trigger_tx_scheduler #(
    .TRIG_LEN(4), .STATUS_LEN(8), .GAP_BYTES(2), .STATUS_PERIOD(100), .ADDR_W(4), .DROP_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_tick  (byte_tick),
    .enable     (enable),
    .trig_req   (trig_req),
    .status_req (status_req),
    .addr       (addr),
    .is_trigger (is_trigger),
    .byte_valid (byte_valid),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit tr, input bit sr, input bit bv, input int a, input bit it,
                     input bit fs, input bit fd, input bit fa, input bit bs);
    vec_t v;
    v.tr = tr; v.sr = sr; v.bv = bv; v.a = 4'(a); v.it = it;
    v.fs = fs; v.fd = fd; v.fa = fa; v.bs = bs;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    trig_req = 1'b1;
    @(negedge clk);
    trig_req = 1'b0;
  endtask

  // Optional request pulse, then one byte tick; returns on the negedge where its outputs are visible.
  task automatic do_tick(input bit tr, input bit sr);
    repeat (6) @(negedge clk);
    if (tr || sr) begin
      @(negedge clk);
      trig_req = tr;
      status_req = sr;
      @(negedge clk);
      trig_req = 1'b0;
      status_req = 1'b0;
    end
    @(negedge clk);
    byte_tick = 1'b1;
    @(negedge clk);
    byte_tick = 1'b0;
  endtask

  function automatic logic [9:0] row_act();
    return {byte_valid, addr, is_trigger, frame_start, frame_done, frame_abort, busy};
  endfunction

  initial begin
    int starts[$];
    int start_it;
    int nbytes;
    int ndone;
    int nstart;
    int nbv;

    // tr sr | bv addr it fs fd fa busy
    add(1,0, 1,0,1,1,0,0,1);
    for (int a = 1; a < 4; a++) add(0,0, 1,a,1,0,(a==3),0,1);
    add(0,0, 0,3,1,0,0,0,1);
    add(0,0, 0,0,1,0,0,0,0);
    add(0,0, 0,0,1,0,0,0,0);
    add(1,1, 1,0,1,1,0,0,1);
    for (int a = 1; a < 4; a++) add(0,0, 1,a,1,0,(a==3),0,1);
    add(0,0, 0,3,1,0,0,0,1);
    add(0,0, 0,0,1,0,0,0,0);
    add(0,0, 1,0,0,1,0,0,1);
    for (int a = 1; a < 4; a++) add(0,0, 1,a,0,0,0,0,1);
    add(1,0, 1,0,1,1,0,1,1);
    for (int a = 1; a < 4; a++) add(0,0, 1,a,1,0,(a==3),0,1);
    add(0,0, 0,3,1,0,0,0,1);
    add(0,0, 0,0,1,0,0,0,0);
    add(0,0, 1,0,0,1,0,0,1);
    for (int a = 1; a < 8; a++) add(0,0, 1,a,0,0,(a==7),0,1);
    add(0,0, 0,7,0,0,0,0,1);
    add(0,0, 0,0,0,0,0,0,0);
    add(0,1, 1,0,0,1,0,0,1);
    for (int a = 1; a < 8; a++) add(0,0, 1,a,0,0,(a==7),0,1);
    add(1,0, 0,7,0,0,0,0,1);
    add(0,0, 0,0,0,0,0,0,0);
    add(0,0, 1,0,1,1,0,0,1);
    for (int a = 1; a < 4; a++) add(0,0, 1,a,1,0,(a==3),0,1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 0,
        {addr, is_trigger, byte_valid, frame_start, frame_done, frame_abort, busy, drop_count}, 0);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Basic trigger, simultaneous requests, preemption, last-byte no-abort
    foreach (vq[i]) begin
      do_tick(vq[i].tr, vq[i].sr);
      chk("vec", i, row_act(),
          {vq[i].bv, vq[i].a, vq[i].it, vq[i].fs, vq[i].fd, vq[i].fa, vq[i].bs});
    end
    chk("vec_drop", 0, drop_count, 0);

    // Periodic status frames
    do_reset();
    enable = 1'b1;
    nbytes = 0;
    ndone = 0;
    start_it = 0;
    for (int t = 0; t < 250; t++) begin
      do_tick(0, 0);
      if (frame_start) begin
        starts.push_back(t);
        start_it += int'(is_trigger);
      end
      if (byte_valid) nbytes++;
      if (frame_done) ndone++;
    end
    chk("periodic_nstarts", 0, starts.size(), 2);
    if (starts.size() == 2) begin
      chk("periodic_start", 0, starts[0], 100);
      chk("periodic_start", 1, starts[1], 200);
    end
    chk("periodic_is_trigger", 0, start_it, 0);
    chk("periodic_bytes", 0, nbytes, 16);
    chk("periodic_done", 0, ndone, 2);

    // Overrun: one queued, one dropped inside a trigger frame
    do_reset();
    enable = 1'b1;
    do_tick(1, 0);
    chk("ovr_first", 0, {byte_valid, frame_start, is_trigger}, 3'b111);
    do_tick(0, 0);
    pulse_trig();
    chk("ovr_queue_drop", 0, drop_count, 0);
    do_tick(0, 0);
    pulse_trig();
    chk("ovr_drop", 0, drop_count, 1);
    nstart = 0;
    for (int t = 0; t < 14; t++) begin
      do_tick(0, 0);
      if (frame_start && is_trigger) nstart++;
    end
    chk("ovr_extra_frames", 0, nstart, 1);
    chk("ovr_drop_after", 0, drop_count, 1);

    // Overrun saturation with frames held off
    do_reset();
    enable = 1'b0;
    for (int i = 1; i <= 301; i++) begin
      pulse_trig();
      if (i == 200) chk("sat_drop", 200, drop_count, 199);
      if (i == 256) chk("sat_drop", 256, drop_count, 255);
    end
    chk("sat_drop", 301, drop_count, 255);

    // Enable dropped mid-frame
    do_reset();
    enable = 1'b1;
    do_tick(1, 0);
    enable = 1'b0;
    do_tick(0, 1);
    chk("en_continue", 0, {byte_valid, addr}, {1'b1, 4'd1});
    do_tick(0, 0);
    do_tick(0, 0);
    chk("en_done", 0, {byte_valid, frame_done, addr}, {2'b11, 4'd3});
    nbv = 0;
    for (int t = 0; t < 7; t++) begin
      do_tick(0, 0);
      if (byte_valid) nbv++;
    end
    chk("en_silent", 0, nbv, 0);
    chk("en_idle_busy", 0, busy, 0);
    enable = 1'b1;
    do_tick(0, 0);
    chk("en_resume", 0, {byte_valid, frame_start, is_trigger, addr, busy}, {3'b110, 4'd0, 1'b1});

    // Asynchronous reset mid status frame
    do_reset();
    enable = 1'b1;
    do_tick(0, 1);
    for (int t = 0; t < 5; t++) do_tick(0, 0);
    chk("rst_pre", 0, {byte_valid, is_trigger, addr}, {2'b10, 4'd5});
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", 0,
        {addr, is_trigger, byte_valid, frame_start, frame_done, frame_abort, busy, drop_count}, 0);
    @(negedge clk);
    reset = 1'b1;
    do_tick(1, 0);
    chk("rst_trig0", 0, row_act(), {1'b1, 4'd0, 5'b11001});
    for (int t = 0; t < 3; t++) do_tick(0, 0);
    chk("rst_trig3", 0, row_act(), {1'b1, 4'd3, 5'b10101});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
